// File: rtl/unsigned_div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock from a
// WIDTH+1 bit trial subtraction, with a start/done handshake and busy stall.
module unsigned_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nx;
  logic [WIDTH-1:0]      dq;
  logic [WIDTH-1:0]      d;
  logic [WIDTH:0]        pr;
  logic [CW-1:0]         cnt;

  logic [WIDTH:0]        shifted;
  logic signed [WIDTH:0] t;
  logic                  qbit;
  logic [WIDTH-1:0]      dq_nx;
  logic [WIDTH:0]        pr_nx;
  logic                  last;

  function automatic logic signed [WIDTH:0] trial_sub(input logic [WIDTH:0]   num,
                                                      input logic [WIDTH-1:0] den);
    return $signed(num) - $signed({1'b0, den});
  endfunction

  // One restoring step: keep the difference only when it did not go negative.
  always_comb begin
    shifted = {pr[WIDTH-1:0], dq[WIDTH-1]};
    t       = trial_sub(shifted, d);
    qbit    = ~t[WIDTH];
    dq_nx   = {dq[WIDTH-2:0], qbit};
    pr_nx   = qbit ? $unsigned(t) : shifted;
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (B == '0) ? DONE : RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq          <= '0;
      d           <= '0;
      pr          <= '0;
      cnt         <= '0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_nx == RUN);
      done <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            dq  <= A;
            d   <= B;
            pr  <= '0;
            cnt <= '0;
            // Zero divisor short-circuits straight to the result.
            if (B == '0) begin
              Q           <= '1;
              R           <= A;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          dq  <= dq_nx;
          pr  <= pr_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            Q           <= dq_nx;
            R           <= pr_nx[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_div.sv
// Bench for unsigned_div: a transaction-level model checked every cycle, plus
// directed vectors with literal quotients/remainders and latency checks.
module tb_unsigned_div;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A, B;
  logic [WIDTH-1:0] Q, R;
  logic             busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  unsigned_div #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op with nonzero divisor finishes WIDTH
  // edges later with plain / and %; a zero divisor finishes immediately.
  logic [WIDTH-1:0] m_q, m_r, p_q, p_r;
  logic             m_busy, m_done, m_dbz;
  int               m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0; m_r <= '0; p_q <= '0; p_r <= '0;
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1;
        m_q <= p_q; m_r <= p_r; m_dbz <= 1'b0;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (start) begin
      if (B == 0) begin
        m_q <= '1; m_r <= A; m_dbz <= 1'b1; m_done <= 1'b1;
      end else begin
        p_q <= A / B; p_r <= A % B; m_left <= WIDTH; m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_q", Q, m_q);
      check("cyc_r", R, m_r);
      check("cyc_busy", busy, m_busy);
      check("cyc_done", done, m_done);
      check("cyc_dbz", div_by_zero, m_dbz);
    end
  end

  // Counts edges from the edge before start is raised until done is seen;
  // start is dropped right after the accepting edge and A/B are scrambled.
  task automatic do_op(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                       input logic edbz, input int elat);
    int n = 0;
    bit got = 0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    while (!got && n < 40) begin
      @(posedge clk); n++; #1;
      if (n == 1) begin
        start = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom);
      end
      if (done) got = 1;
    end
    check({nm, "_got_done"}, got, 1'b1);
    check({nm, "_latency"}, n, elat);
    check({nm, "_q"}, Q, eq);
    check({nm, "_r"}, R, er);
    check({nm, "_dbz"}, div_by_zero, edbz);
    if (edbz) check({nm, "_busy"}, busy, 1'b0);
    @(posedge clk); #1;
    check({nm, "_done_one_cycle"}, done, 1'b0);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); n++; #1;
    end
    check({nm, "_done_seen"}, done, 1'b1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int dcount;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    #1;
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; chk_en = 1'b1;

    do_op("d1000_7",  16'd1000,  16'd7,     16'd142,   16'd6,    1'b0, 17);
    do_op("d50000",   16'd50000, 16'd256,   16'd195,   16'd80,   1'b0, 17);
    do_op("d5_9",     16'd5,     16'd9,     16'd0,     16'd5,    1'b0, 17);
    do_op("dmax_1",   16'd65535, 16'd1,     16'd65535, 16'd0,    1'b0, 17);
    do_op("dmax_max", 16'd65535, 16'd65535, 16'd1,     16'd0,    1'b0, 17);
    do_op("d0_0",     16'd0,     16'd0,     16'hFFFF,  16'd0,    1'b1, 1);
    do_op("d1234_0",  16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1, 1);
    do_op("d0_5",     16'd0,     16'd5,     16'd0,     16'd0,    1'b0, 17);

    // Start pulse mid-run with new operands must be ignored.
    @(negedge clk); A = 16'd1000; B = 16'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; A = 16'd9; B = 16'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; A = 16'd77; B = 16'd0;
    wait_done("midstart");
    check("midstart_q", Q, 142);
    check("midstart_r", R, 6);
    @(posedge clk); #1;

    // Start held high through DONE is taken only on the following IDLE cycle.
    @(negedge clk); A = 16'd1000; B = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    wait_done("b2b");
    @(posedge clk); #1;
    check("b2b_idle_busy", busy, 0);
    @(posedge clk); #1;
    check("b2b_accept_busy", busy, 1);
    start = 1'b0;
    wait_done("b2b2");
    check("b2b2_q", Q, 142);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run.
    @(negedge clk); A = 16'd1000; B = 16'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("arst_q", Q, 0);
    check("arst_r", R, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk); rst = 1'b0;
    dcount = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("arst_no_done", dcount, 0);
    do_op("post_rst", 16'd1000, 16'd7, 16'd142, 16'd6, 1'b0, 17);

    // Random operands checked against the division identity.
    for (int i = 0; i < 1500; i++) begin
      ra = WIDTH'($urandom);
      rb = (i % 4 == 0) ? WIDTH'($urandom_range(1, 15)) : WIDTH'($urandom_range(1, 65535));
      do_op("rand", ra, rb, ra / rb, ra % rb, 1'b0, 17);
      check("rand_identity", 32'(Q) * 32'(rb) + 32'(R), 32'(ra));
      check("rand_r_lt_b", (R < rb), 1'b1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
